uart_tx_queue: RTL and testbench

Byte-queue front end for the UART transmit path of the single-cycle CPU. It accepts bytes from the CPU's memory-mapped UART data register, buffers them in a FIFO, and hands them one at a time to the UART sender using the sender's pulse/status handshake. The handshake is a one-cycle `tx_en` pulse, then `tx_status` low while busy, then high when the frame is done. It sits between the peripheral bus decode and the UART sender.

---
 rtl/uart_pkg.sv | 15 +
 rtl/sync_fifo.sv | 61 ++++++
 rtl/uart_tx_queue.sv | 136 +++++++++++++
 tb/tb_uart_tx_queue.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Constants and FSM state type shared by the UART transmit and receive queues.
package uart_pkg;

  localparam int UART_BYTE_W       = 8;
  localparam int UART_Q_DEPTH      = 16;
  localparam int UART_BUSY_TIMEOUT = 15;

  typedef enum logic [1:0] {
    TXQ_IDLE      = 2'd0,
    TXQ_LAUNCH    = 2'd1,
    TXQ_WAIT_BUSY = 2'd2,
    TXQ_WAIT_DONE = 2'd3
  } txq_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers. Supports a synchronous flush that
// discards the queued contents and any write presented in the same cycle.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH),
  parameter int W     = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  input  logic          flush,
  output logic [W-1:0]  rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_wr;
  logic         do_rd;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level = wr_ptr_q - rd_ptr_q;

  assign do_rd = rd_en && !empty;
  // A full queue still takes a write when a pop frees a slot in the same cycle.
  assign do_wr = wr_en && !flush && (!full || do_rd);

  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (flush) rd_ptr_d = wr_ptr_q;
    else if (do_rd) rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_queue.sv
// UART transmit byte queue: buffers CPU writes and feeds the sender one byte
// at a time over the tx_en pulse / tx_status handshake.
//   state     | meaning
//   IDLE      | waiting for a queued byte and an idle sender
//   LAUNCH    | tx_en high for one cycle, tx_data holds the popped byte
//   WAIT_BUSY | waiting for the sender to go busy, bounded by BUSY_TIMEOUT
//   WAIT_DONE | frame in progress, waiting for the sender to go idle
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int DEPTH        = UART_Q_DEPTH,
  parameter int AW           = $clog2(DEPTH),
  parameter int BUSY_TIMEOUT = UART_BUSY_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [UART_BYTE_W-1:0] wr_data,
  input  logic                   flush,
  input  logic                   clr_err,
  input  logic                   tx_status,
  output logic                   tx_en,
  output logic [UART_BYTE_W-1:0] tx_data,
  output logic                   full,
  output logic                   empty,
  output logic [AW:0]            level,
  output logic                   overflow,
  output logic                   timeout,
  output logic                   done_pulse
);

  localparam int CW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BUSY_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  txq_state_e             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [UART_BYTE_W-1:0] tx_data_q, tx_data_d;
  logic                   overflow_q, overflow_d;
  logic                   timeout_q, timeout_d;
  logic                   done_q, done_d;
  logic                   pop;
  logic                   ovf_set;
  logic                   to_set;
  logic [UART_BYTE_W-1:0] fifo_rd_data;
  logic                   fifo_full;
  logic                   fifo_empty;

  sync_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (UART_BYTE_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (pop),
    .flush   (flush),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

  assign pop     = (state_q == TXQ_IDLE) && !fifo_empty && tx_status;
  // A write lost to flush is intentional, so only a genuinely full queue flags it.
  assign ovf_set = wr_en && !flush && fifo_full && !pop;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tx_data_d = tx_data_q;
    done_d    = 1'b0;
    to_set    = 1'b0;
    case (state_q)
      TXQ_IDLE: begin
        if (pop) begin
          tx_data_d = fifo_rd_data;
          state_d   = TXQ_LAUNCH;
        end
      end
      TXQ_LAUNCH: begin
        cnt_d   = '0;
        state_d = TXQ_WAIT_BUSY;
      end
      TXQ_WAIT_BUSY: begin
        if (!tx_status) begin
          state_d = TXQ_WAIT_DONE;
        end else if (cnt_q == CNT_LAST) begin
          to_set  = 1'b1;
          state_d = TXQ_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      TXQ_WAIT_DONE: begin
        if (tx_status) begin
          done_d  = 1'b1;
          state_d = TXQ_IDLE;
        end
      end
      default: state_d = TXQ_IDLE;
    endcase
  end

  assign overflow_d = ovf_set | (overflow_q & ~clr_err);
  assign timeout_d  = to_set  | (timeout_q  & ~clr_err);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= TXQ_IDLE;
      cnt_q      <= '0;
      tx_data_q  <= '0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      overflow_q <= overflow_d;
      timeout_q  <= timeout_d;
      done_q     <= done_d;
    end
  end

  assign tx_en      = (state_q == TXQ_LAUNCH);
  assign tx_data    = tx_data_q;
  assign full       = fifo_full;
  assign empty      = fifo_empty;
  assign overflow   = overflow_q;
  assign timeout    = timeout_q;
  assign done_pulse = done_q;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue: behavioural sender model, launch log and per-feature tasks.
`timescale 1ns/1ps
module tb_uart_tx_queue;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int BT    = 15;

  logic          clk       = 1'b0;
  logic          reset     = 1'b0;
  logic          wr_en     = 1'b0;
  logic [7:0]    wr_data   = 8'h00;
  logic          flush     = 1'b0;
  logic          clr_err   = 1'b0;
  logic          tx_status = 1'b1;
  logic          tx_en;
  logic [7:0]    tx_data;
  logic          full;
  logic          empty;
  logic [AW:0]   level;
  logic          overflow;
  logic          timeout;
  logic          done_pulse;

  int n_vec = 0;
  int n_err = 0;

  // Sender model controls and observation log
  int         busy_len   = 20;
  bit         snd_stall  = 1'b0;
  bit         snd_deaf   = 1'b0;
  int         snd_dly    = 0;
  int         snd_left   = 0;
  logic [7:0] launch_log [0:1023];
  int         launch_cnt = 0;
  int         done_cnt   = 0;
  int         consec_cnt = 0;
  bit         tx_en_prev = 1'b0;

  always #5 clk = ~clk;

  uart_tx_queue #(.DEPTH(DEPTH), .BUSY_TIMEOUT(BT)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .flush      (flush),
    .clr_err    (clr_err),
    .tx_status  (tx_status),
    .tx_en      (tx_en),
    .tx_data    (tx_data),
    .full       (full),
    .empty      (empty),
    .level      (level),
    .overflow   (overflow),
    .timeout    (timeout),
    .done_pulse (done_pulse)
  );

  // Sender: busy two edges after it sees tx_en, busy for busy_len cycles.
  always @(negedge clk) begin
    if (tx_en === 1'b1) begin
      launch_log[launch_cnt[9:0]] = tx_data;
      launch_cnt++;
      if (tx_en_prev) consec_cnt++;
    end
    if (done_pulse === 1'b1) done_cnt++;
    tx_en_prev = (tx_en === 1'b1);
    if (!reset) begin
      snd_dly = 0; snd_left = 0; tx_status = 1'b1;
    end else if (snd_stall) begin
      snd_dly = 0; snd_left = 0; tx_status = 1'b0;
    end else if (tx_en === 1'b1) begin
      if (!snd_deaf) snd_dly = 2;
    end else if (snd_dly > 0) begin
      snd_dly--;
      if (snd_dly == 0) begin
        tx_status = 1'b0;
        snd_left  = busy_len;
      end
    end else if (snd_left > 0) begin
      snd_left--;
      if (snd_left == 0) tx_status = 1'b1;
    end else begin
      tx_status = 1'b1;
    end
  end

  task automatic test_reset();
    @(negedge clk);
    n_vec++;
    if ({tx_en, full, overflow, timeout, done_pulse, empty} !== 6'b000001) begin
      n_err++;
      $display("FAIL reset_flags got %b exp 000001", {tx_en, full, overflow, timeout, done_pulse, empty});
    end
    n_vec++;
    if (level !== 5'd0) begin n_err++; $display("FAIL reset_level got %0d exp 0", level); end
    n_vec++;
    if (tx_data !== 8'h00) begin n_err++; $display("FAIL reset_tx_data got %h exp 00", tx_data); end
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    int lc0, dc0, bad_hold;
    lc0 = launch_cnt; dc0 = done_cnt; busy_len = 640;
    wr_en = 1'b1; wr_data = 8'hA5;
    @(negedge clk);
    wr_en = 1'b0;
    n_vec++;
    if (level !== 5'd1) begin n_err++; $display("FAIL single_level_k got %0d exp 1", level); end
    @(negedge clk);
    n_vec++;
    if (level !== 5'd0) begin n_err++; $display("FAIL single_level_k1 got %0d exp 0", level); end
    n_vec++;
    if (tx_en !== 1'b1) begin n_err++; $display("FAIL single_tx_en got %b exp 1", tx_en); end
    n_vec++;
    if (tx_data !== 8'hA5) begin n_err++; $display("FAIL single_tx_data got %h exp a5", tx_data); end
    bad_hold = 0;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      if (tx_data !== 8'hA5) bad_hold++;
    end
    n_vec++;
    if (bad_hold != 0) begin n_err++; $display("FAIL single_hold got %0d bad cycles exp 0", bad_hold); end
    n_vec++;
    if (launch_cnt - lc0 != 1) begin n_err++; $display("FAIL single_launches got %0d exp 1", launch_cnt - lc0); end
    n_vec++;
    if (done_cnt - dc0 != 1) begin n_err++; $display("FAIL single_done got %0d exp 1", done_cnt - dc0); end
    n_vec++;
    if (empty !== 1'b1) begin n_err++; $display("FAIL single_empty got %b exp 1", empty); end
  endtask

  task automatic test_burst();
    int lc0, dc0, max_lvl;
    bit full_seen;
    lc0 = launch_cnt; dc0 = done_cnt; busy_len = 20; max_lvl = 0; full_seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      @(negedge clk);
      if (int'(level) > max_lvl) max_lvl = int'(level);
      if (full === 1'b1) full_seen = 1'b1;
    end
    wr_en = 1'b0;
    for (int c = 0; c < 1500 && (done_cnt - dc0) < 16; c++) begin
      @(negedge clk);
      if (int'(level) > max_lvl) max_lvl = int'(level);
      if (full === 1'b1) full_seen = 1'b1;
    end
    n_vec++;
    if (done_cnt - dc0 != 16) begin n_err++; $display("FAIL burst_done got %0d exp 16", done_cnt - dc0); end
    n_vec++;
    if (launch_cnt - lc0 != 16) begin n_err++; $display("FAIL burst_launches got %0d exp 16", launch_cnt - lc0); end
    n_vec++;
    if (full_seen) begin n_err++; $display("FAIL burst_full got 1 exp 0"); end
    n_vec++;
    if (max_lvl != 15) begin n_err++; $display("FAIL burst_peak_level got %0d exp 15", max_lvl); end
    for (int i = 0; i < 16; i++) begin
      n_vec++;
      if (launch_log[lc0 + i] !== 8'(i)) begin
        n_err++; $display("FAIL burst_order[%0d] got %h exp %h", i, launch_log[lc0 + i], 8'(i));
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] exp_b [16];
    int lc0, dc0;
    lc0 = launch_cnt; dc0 = done_cnt;
    snd_stall = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      exp_b[i] = 8'($urandom_range(0, 255));
      wr_en = 1'b1; wr_data = exp_b[i];
      @(negedge clk);
    end
    wr_en = 1'b0;
    n_vec++;
    if (full !== 1'b1) begin n_err++; $display("FAIL ovf_full got %b exp 1", full); end
    n_vec++;
    if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_early got %b exp 0", overflow); end
    wr_en = 1'b1; wr_data = 8'($urandom_range(0, 255));
    @(negedge clk);
    wr_en = 1'b0;
    n_vec++;
    if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set got %b exp 1", overflow); end
    n_vec++;
    if (level !== 5'd16) begin n_err++; $display("FAIL ovf_level got %0d exp 16", level); end
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    n_vec++;
    if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear got %b exp 0", overflow); end
    busy_len = int'($urandom_range(3, 25));
    snd_stall = 1'b0;
    for (int c = 0; c < 2000 && (done_cnt - dc0) < 16; c++) @(negedge clk);
    n_vec++;
    if (launch_cnt - lc0 != 16) begin n_err++; $display("FAIL ovf_drain got %0d exp 16", launch_cnt - lc0); end
    for (int i = 0; i < 16; i++) begin
      n_vec++;
      if (launch_log[lc0 + i] !== exp_b[i]) begin
        n_err++; $display("FAIL ovf_order[%0d] got %h exp %h", i, launch_log[lc0 + i], exp_b[i]);
      end
    end
  endtask

  task automatic test_timeout();
    logic [7:0] b1, b2;
    int cyc, dc0;
    b1 = 8'($urandom_range(0, 255)); b2 = 8'($urandom_range(0, 255));
    busy_len = 10; snd_deaf = 1'b1;
    wr_en = 1'b1; wr_data = b1;
    @(negedge clk);
    wr_data = b2;
    @(negedge clk);
    wr_en = 1'b0;
    n_vec++;
    if (tx_en !== 1'b1 || tx_data !== b1) begin
      n_err++; $display("FAIL to_launch1 got en=%b data=%h exp en=1 data=%h", tx_en, tx_data, b1);
    end
    cyc = 0;
    while (timeout !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    n_vec++;
    if (cyc != BT + 1) begin n_err++; $display("FAIL to_cycles got %0d exp %0d", cyc, BT + 1); end
    snd_deaf = 1'b0;
    dc0 = done_cnt;
    @(negedge clk);
    n_vec++;
    if (tx_en !== 1'b1 || tx_data !== b2) begin
      n_err++; $display("FAIL to_launch2 got en=%b data=%h exp en=1 data=%h", tx_en, tx_data, b2);
    end
    for (int c = 0; c < 200 && done_cnt == dc0; c++) @(negedge clk);
    n_vec++;
    if (done_cnt - dc0 != 1) begin n_err++; $display("FAIL to_done2 got %0d exp 1", done_cnt - dc0); end
    n_vec++;
    if (timeout !== 1'b1) begin n_err++; $display("FAIL to_sticky got %b exp 1", timeout); end
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    n_vec++;
    if (timeout !== 1'b0) begin n_err++; $display("FAIL to_clear got %b exp 0", timeout); end
  endtask

  task automatic test_flush();
    logic [7:0] b0;
    int lc0, dc0;
    lc0 = launch_cnt; dc0 = done_cnt; busy_len = 60;
    b0 = 8'($urandom_range(0, 255));
    wr_en = 1'b1; wr_data = b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      wr_data = 8'($urandom_range(0, 255));
      @(negedge clk);
    end
    n_vec++;
    if (level !== 5'd5) begin n_err++; $display("FAIL flush_pre_level got %0d exp 5", level); end
    flush = 1'b1; wr_data = 8'($urandom_range(0, 255));
    @(negedge clk);
    flush = 1'b0; wr_en = 1'b0;
    n_vec++;
    if (level !== 5'd0 || empty !== 1'b1) begin
      n_err++; $display("FAIL flush_level got %0d empty=%b exp 0 empty=1", level, empty);
    end
    n_vec++;
    if (tx_data !== b0) begin n_err++; $display("FAIL flush_tx_data got %h exp %h", tx_data, b0); end
    n_vec++;
    if (overflow !== 1'b0) begin n_err++; $display("FAIL flush_ovf got %b exp 0", overflow); end
    for (int c = 0; c < 300 && done_cnt == dc0; c++) @(negedge clk);
    n_vec++;
    if (done_cnt - dc0 != 1) begin n_err++; $display("FAIL flush_done got %0d exp 1", done_cnt - dc0); end
    repeat (40) @(negedge clk);
    n_vec++;
    if (launch_cnt - lc0 != 1) begin n_err++; $display("FAIL flush_launches got %0d exp 1", launch_cnt - lc0); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    int lc0, dc0, cyc;
    busy_len = 50;
    wr_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_data = 8'($urandom_range(0, 255));
      @(negedge clk);
    end
    wr_en = 1'b0;
    cyc = 0;
    while (tx_status !== 1'b0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    repeat (2) @(negedge clk);
    n_vec++;
    if (level !== 5'd3 || tx_status !== 1'b0) begin
      n_err++; $display("FAIL rstmid_pre got level=%0d status=%b exp level=3 status=0", level, tx_status);
    end
    reset = 1'b0;
    #1;
    n_vec++;
    if ({tx_en, full, overflow, timeout, done_pulse, empty} !== 6'b000001 || level !== 5'd0 || tx_data !== 8'h00) begin
      n_err++;
      $display("FAIL rstmid_values got flags=%b level=%0d data=%h exp flags=000001 level=0 data=00",
               {tx_en, full, overflow, timeout, done_pulse, empty}, level, tx_data);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    lc0 = launch_cnt;
    repeat (30) @(negedge clk);
    n_vec++;
    if (launch_cnt != lc0 || empty !== 1'b1) begin
      n_err++; $display("FAIL rstmid_quiet got launches=%0d empty=%b exp 0 empty=1", launch_cnt - lc0, empty);
    end
    b = 8'($urandom_range(0, 255));
    dc0 = done_cnt;
    wr_en = 1'b1; wr_data = b;
    @(negedge clk);
    wr_en = 1'b0;
    for (int c = 0; c < 200 && done_cnt == dc0; c++) @(negedge clk);
    n_vec++;
    if (launch_cnt - lc0 != 1 || launch_log[lc0] !== b) begin
      n_err++; $display("FAIL rstmid_relaunch got n=%0d data=%h exp n=1 data=%h", launch_cnt - lc0, launch_log[lc0], b);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b [12];
    int lc0, dc0, n, gap;
    for (int r = 0; r < 5; r++) begin
      n = int'($urandom_range(1, 12));
      busy_len = int'($urandom_range(1, 30));
      lc0 = launch_cnt; dc0 = done_cnt;
      for (int i = 0; i < n; i++) begin
        exp_b[i] = 8'($urandom_range(0, 255));
        wr_en = 1'b1; wr_data = exp_b[i];
        @(negedge clk);
        wr_en = 1'b0;
        gap = int'($urandom_range(0, 3));
        repeat (gap) @(negedge clk);
      end
      for (int c = 0; c < 3000 && (done_cnt - dc0) < n; c++) @(negedge clk);
      n_vec++;
      if (launch_cnt - lc0 != n) begin
        n_err++; $display("FAIL b2b_count round %0d got %0d exp %0d", r, launch_cnt - lc0, n);
      end
      for (int i = 0; i < n; i++) begin
        n_vec++;
        if (launch_log[lc0 + i] !== exp_b[i]) begin
          n_err++; $display("FAIL b2b_order r%0d[%0d] got %h exp %h", r, i, launch_log[lc0 + i], exp_b[i]);
        end
      end
    end
    n_vec++;
    if (consec_cnt != 0) begin n_err++; $display("FAIL b2b_consec_tx_en got %0d exp 0", consec_cnt); end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_timeout();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
